// File: rtl/hx8352_pkg.sv
// Shared encodings for the HX8352 register writer.
// HX8352_DELAY_CMD_EN adds the DLY state for in-sequence delays.
package hx8352_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_REQ,
    T_WAIT,
    T_IDX,
    T_VAL,
    T_DONE,
    T_ERR
`ifdef HX8352_DELAY_CMD_EN
    , T_DLY
`endif
  } top_st_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRL,
    S_WRH
  } wr_st_t;

  localparam logic [7:0] CMD_DONE  = 8'hFF;
  localparam logic [7:0] CMD_DELAY = 8'hFE;

  localparam logic IDX = 1'b0;
  localparam logic VAL = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hx8352_wr_strobe.sv
// Single-byte 8080 write timer: SETUP, WR low, WR high, then ack.
// A go during the ack cycle chains the next byte with no idle gap.
import hx8352_pkg::*;

module hx8352_wr_strobe #(
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        phase,
  input  logic [7:0]  wbyte,
  output logic        wr_n,
  output logic        rs,
  output logic [15:0] data,
  output logic        ack
);

  localparam int CW = $clog2(max2(max2(SETUP_CYCLES, WR_LOW_CYCLES),
                                  WR_HIGH_CYCLES) + 1);
  localparam logic [CW-1:0] SET_L  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LOW_L  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_L = CW'(WR_HIGH_CYCLES - 1);

  wr_st_t        st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load;

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt + 1'b1;
    load   = 1'b0;
    ack    = 1'b0;
    unique case (st)
      S_IDLE: begin
        cnt_nx = '0;
        if (go) begin
          st_nx = S_SETUP;
          load  = 1'b1;
        end
      end
      S_SETUP: if (cnt == SET_L) begin
        st_nx  = S_WRL;
        cnt_nx = '0;
      end
      S_WRL: if (cnt == LOW_L) begin
        st_nx  = S_WRH;
        cnt_nx = '0;
      end
      S_WRH: if (cnt == HIGH_L) begin
        ack    = 1'b1;
        cnt_nx = '0;
        if (go) begin
          st_nx = S_SETUP;
          load  = 1'b1;
        end else begin
          st_nx = S_IDLE;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // rs/data move only when a SETUP phase is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_IDLE;
      cnt  <= '0;
      rs   <= 1'b1;
      data <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      if (load) begin
        rs   <= phase;
        data <= {8'h00, wbyte};
      end
    end
  end

  assign wr_n = (st != S_WRL);

endmodule

// File: rtl/hx8352_reg_writer.sv
// Executes sequencer cmd/value pairs as index+data writes on the LCD bus.
// HX8352_DELAY_CMD_EN turns cmd 8'hFE into a value-scaled delay.
import hx8352_pkg::*;

module hx8352_reg_writer #(
  parameter int SETUP_CYCLES      = 1,
  parameter int WR_LOW_CYCLES     = 2,
  parameter int WR_HIGH_CYCLES    = 2,
  parameter int WAIT_TIMEOUT      = 1023,
  parameter int DELAY_UNIT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [7:0]  value,
  input  logic        data_rdy,
  input  logic        finish,
  output logic        next,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_data,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  // WAIT timeout and DLY unit count share one counter
  localparam int CW = $clog2(max2(WAIT_TIMEOUT, DELAY_UNIT_CYCLES) + 1);
  localparam logic [CW-1:0] TMO_L = CW'(WAIT_TIMEOUT - 1);

  top_st_t       st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    val_q, val_nx;
  logic          go, ph, ack;
  logic [7:0]    wbyte;

`ifdef HX8352_DELAY_CMD_EN
  localparam logic [CW-1:0] UNIT_L = CW'(DELAY_UNIT_CYCLES - 1);
  logic [7:0] dly_q, dly_nx;
`endif

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    val_nx = val_q;
    go     = 1'b0;
    ph     = IDX;
    wbyte  = cmd;
    next   = 1'b0;
`ifdef HX8352_DELAY_CMD_EN
    dly_nx = dly_q;
`endif
    unique case (st)
      T_IDLE: if (start) st_nx = T_REQ;
      T_REQ: begin
        next   = 1'b1;
        cnt_nx = '0;
        st_nx  = T_WAIT;
      end
      T_WAIT: begin
        if (data_rdy && cmd != CMD_DONE) begin
          val_nx = value;
          cnt_nx = '0;
          go     = 1'b1;
          st_nx  = T_IDX;
`ifdef HX8352_DELAY_CMD_EN
          if (cmd == CMD_DELAY) begin
            go     = 1'b0;
            dly_nx = value;
            st_nx  = T_DLY;
          end
`endif
        end else if (finish || data_rdy) begin
          st_nx = T_DONE;
        end else if (cnt == TMO_L) begin
          st_nx = T_ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      T_IDX: begin
        ph    = VAL;
        wbyte = val_q;
        if (ack) begin
          go    = 1'b1;
          st_nx = T_VAL;
        end
      end
      T_VAL: if (ack) st_nx = T_REQ;
`ifdef HX8352_DELAY_CMD_EN
      T_DLY: begin
        if (dly_q == 8'd0) begin
          st_nx = T_REQ;
        end else if (cnt == UNIT_L) begin
          cnt_nx = '0;
          dly_nx = dly_q - 8'd1;
          if (dly_q == 8'd1) st_nx = T_REQ;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`endif
      default: st_nx = st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= T_IDLE;
      cnt   <= '0;
      val_q <= '0;
`ifdef HX8352_DELAY_CMD_EN
      dly_q <= '0;
`endif
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      val_q <= val_nx;
`ifdef HX8352_DELAY_CMD_EN
      dly_q <= dly_nx;
`endif
    end
  end

  hx8352_wr_strobe #(
    .SETUP_CYCLES   (SETUP_CYCLES),
    .WR_LOW_CYCLES  (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .phase (ph),
    .wbyte (wbyte),
    .wr_n  (lcd_wr_n),
    .rs    (lcd_rs),
    .data  (lcd_data),
    .ack   (ack)
  );

  assign lcd_cs_n    = !(st == T_IDX || st == T_VAL);
  assign lcd_rd_n    = 1'b1;
  assign busy        = !(st == T_IDLE || st == T_DONE || st == T_ERR);
  assign done        = (st == T_DONE);
  assign timeout_err = (st == T_ERR);

endmodule

// File: tb/tb_hx8352_reg_writer.sv
// Randomized bench: a sequencer model feeds pairs, a bus monitor
// collects writes and pulse widths for comparison with the expected list.
module tb_hx8352_reg_writer;

  logic        clk, rst, start, data_rdy, finish;
  logic [7:0]  cmd, value;
  logic        next, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;
  logic        busy, done, timeout_err;

  hx8352_reg_writer #(.DELAY_UNIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .value(value),
    .data_rdy(data_rdy), .finish(finish), .next(next),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
    .lcd_rd_n(lcd_rd_n), .lcd_data(lcd_data), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  localparam int BYTE_CYC = 1 + 2 + 2;

  int nchk = 0;
  int nerr = 0;

  logic [16:0] wr_q[$];
  logic [16:0] exp_q[$];
  int          lowlen_q[$];
  int          cslen_q[$];
  logic [7:0]  pc[$];
  logic [7:0]  pv[$];
  int          nexts, stable_bad, cs_bad, low_len, cs_len;
  logic        prev_wr, prev_cs;
  logic [16:0] snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b1; prev_cs = 1'b1;
      low_len = 0; cs_len = 0; nexts = 0;
      stable_bad = 0; cs_bad = 0;
      wr_q.delete(); lowlen_q.delete(); cslen_q.delete();
    end else begin
      if (!lcd_wr_n) begin
        if (prev_wr) begin
          snap = {lcd_rs, lcd_data};
          wr_q.push_back(snap);
          low_len = 0;
        end
        low_len++;
        if ({lcd_rs, lcd_data} !== snap) stable_bad++;
        if (lcd_cs_n) cs_bad++;
      end else if (!prev_wr) begin
        lowlen_q.push_back(low_len);
      end
      if (!lcd_cs_n) cs_len++;
      else if (!prev_cs) begin
        cslen_q.push_back(cs_len);
        cs_len = 0;
      end
      if (next) nexts++;
      prev_wr = lcd_wr_n;
      prev_cs = lcd_cs_n;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; data_rdy = 1'b0; finish = 1'b0;
    cmd = 8'h00; value = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_next(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (next) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("next_wait", 0, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_wait", done, 1);
  endtask

  // Serve pc/pv as the sequencer would, then finish; check the bus
  task automatic run_round(input int n, input bit fs, input bit rs_first);
    bit ok;
    if (rs_first) do_reset();
    exp_q.delete();
    start = 1'b1;
    for (int i = 0; i <= n; i++) begin
      wait_next(ok);
      if (!ok) return;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if (i < n) begin
        cmd = pc[i]; value = pv[i]; data_rdy = 1'b1;
        exp_q.push_back({1'b0, 8'h00, pc[i]});
        exp_q.push_back({1'b1, 8'h00, pv[i]});
        if (fs && i == n - 1) finish = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
      end else begin
        finish = 1'b1;
      end
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("n_writes", wr_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < wr_q.size()) chk($sformatf("wr%0d", i), wr_q[i], exp_q[i]);
    chk("next_cnt", nexts, n + 1);
    foreach (lowlen_q[i]) chk("wr_low_len", lowlen_q[i], 2);
    chk("cs_runs", cslen_q.size(), n);
    foreach (cslen_q[i]) chk("cs_len", cslen_q[i], 2 * BYTE_CYC);
    chk("stable", stable_bad, 0);
    chk("cs_in_wr", cs_bad, 0);
    chk("end_busy", busy, 0);
    chk("end_pins", {lcd_cs_n, lcd_wr_n, lcd_rd_n}, 3'b111);
    chk("end_terr", timeout_err, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int gap, n;
    bit found;

    do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_next", next, 0);
    chk("rst_pins", {lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n}, 4'b1111);
    chk("rst_data", lcd_data, 0);
    chk("rst_flags", {busy, done, timeout_err}, 3'b000);
    rst = 1'b0;

    pc = '{8'h22}; pv = '{8'h5A};
    run_round(1, 1'b0, 1'b1);

    pc.delete(); pv.delete();
    for (int i = 0; i < 3; i++) begin
      pc.push_back(8'($urandom_range(0, 253)));
      pv.push_back(8'($urandom_range(0, 255)));
    end
    run_round(3, 1'b0, 1'b1);

    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 5);
      pc.delete(); pv.delete();
      for (int i = 0; i < n; i++) begin
        pc.push_back(8'($urandom_range(0, 253)));
        pv.push_back(8'($urandom_range(0, 255)));
      end
      run_round(n, 1'($urandom_range(0, 1)), 1'b1);
    end

    // data_rdy and finish together: pair must still be written
    pc = '{8'h10, 8'h20}; pv = '{8'hA1, 8'hB2};
    run_round(2, 1'b1, 1'b1);

    // Timeout: no response after next
    do_reset();
    start = 1'b1;
    wait_next(ok);
    repeat (1000) @(negedge clk);
    chk("tmo_early_err", timeout_err, 0);
    chk("tmo_early_busy", busy, 1);
    repeat (40) @(negedge clk);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_flags", {busy, done}, 2'b00);
    chk("tmo_no_wr", wr_q.size(), 0);
    data_rdy = 1'b1; cmd = 8'h01;
    @(negedge clk);
    data_rdy = 1'b0;
    repeat (20) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_still_no_wr", wr_q.size(), 0);

    // Reset during WR low of the data phase, then restart
    do_reset();
    start = 1'b1;
    wait_next(ok);
    @(negedge clk);
    cmd = 8'h11; value = 8'h77; data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!lcd_wr_n && lcd_rs) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midwr_found", found, 1);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("midwr_pins", {lcd_wr_n, lcd_cs_n}, 2'b11);
    chk("midwr_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    pc = '{8'h33}; pv = '{8'h44};
    run_round(1, 1'b0, 1'b0);

    // Delay command
    do_reset();
    start = 1'b1;
    wait_next(ok);
    @(negedge clk);
    cmd = 8'hFE; value = 8'h03; data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    gap = 0;
    for (int k = 1; k < 100; k++) begin
      if (next) begin
        gap = k;
        break;
      end
      @(negedge clk);
    end
    finish = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
`ifdef HX8352_DELAY_CMD_EN
    chk("dly_gap", gap, 1 + 3 * 4);
    chk("dly_no_wr", wr_q.size(), 0);
    chk("dly_no_cs", cslen_q.size(), 0);
`else
    chk("fe_gap", gap, 1 + 2 * BYTE_CYC);
    chk("fe_n_wr", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("fe_idx", wr_q[0], {1'b0, 16'h00FE});
      chk("fe_val", wr_q[1], {1'b1, 16'h0003});
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
